seq_alu_core: RTL
=================

// Module: seq_alu_core
// PURPOSE
//  Parametrised successor of the combined ALU/shifter/multiplier/HI-LO unit in the EX stage.
//  Takes one operation per valid/ready handshake and returns one registered result per op.
//  MULT/MULTU run WIDTH cycles on an internal shift-add engine.
//  Single-cycle ops complete in one cycle.
//  HI/LO are architectural registers: written by multiplies, read back by MFHI/MFLO.
// PARAMETERS
//  WIDTH   32              operand/result width; must be >=4 and a power of 2
//  SHW     $clog2(WIDTH)   shift-amount width (derived; do not override)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  in_valid   in   1      op/data_a/data_b valid
//  in_ready   out  1      core can accept an op this cycle
//  op         in   6      opcode (funct encoding, see BEHAVIOUR)
//  data_a     in   WIDTH  operand A (shift amount source for SRL)
//  data_b     in   WIDTH  operand B (value shifted for SRL)
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  result word
//  out_err    out  1      qualifies result: opcode was unsupported
//  busy       out  1      multiply in progress
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; out_valid=0; result=0; out_err=0; HI=LO=0; busy=0; counter=0.
//  Accept: in_ready = (state==IDLE) && (!out_valid || out_ready). An op is taken on in_valid && in_ready.
//  Opcodes:
//    ADD=32  : A+B (wrap)
//    SUB=34  : A-B (wrap)
//    AND=36, OR=37
//    SLT=42  : signed A<B -> 1 else 0
//    SRL=2   : B >> A[SHW-1:0], logical
//    MFHI=16 : HI
//    MFLO=18 : LO
//    MULTU=25: unsigned multiply
//    MULT=24 : signed two's-complement multiply
//    other   : result=0, out_err=1, HI/LO unchanged, latency 1.
//  Single-cycle ops: result/out_err registered at accept edge; out_valid=1 on the next cycle (latency 1).
//  MFHI/MFLO return HI/LO as of the accept edge.
//  FSM: IDLE -> MUL on multiply accept; MUL -> IDLE when counter reaches WIDTH-1.
//  MUL state: busy=1 and in_ready=0.
//    Latch magnitudes (|A|,|B| for MULT; raw values for MULTU) and the sign = A[msb]^B[msb].
//    One partial-product bit per cycle into a 2*WIDTH accumulator; counter runs 0..WIDTH-1.
//    On the last MUL cycle, product (negated if MULT and sign=1) is written HI=upper and LO=lower;
//    result=LO, out_valid=1 next cycle. Accept-to-out_valid = WIDTH+1 cycles.
//  MULT corner: most-negative x most-negative handled on 2*WIDTH bits (e.g. WIDTH=32: HI=0x40000000, LO=0).
//  Output hold: while out_valid && !out_ready, result/out_err hold stable and no new op is accepted.
//  Back-to-back: out_valid && out_ready with in_valid in the same cycle accepts the next op, 1 op/cycle for single-cycle ops.
//  out_valid drops the cycle after a handshake unless a new result is produced that edge.
//  Multiply + pending output: a multiply completion with an unconsumed previous result cannot happen,
//    since accept requires the output register to be free.
//  Reset mid-multiply: aborts the op; HI/LO return to 0; no out_valid is produced.
//  Inputs are ignored when !in_ready, and op/data need not be held after accept.
// TESTING
//  1 ADD 0xFFFFFFFF+1, SUB 0-1 -> 0x0 then 0xFFFFFFFF; each out_valid 1 cycle after accept; out_err=0.
//  2 MULTU 0xFFFFFFFF*0xFFFFFFFF -> out_valid exactly 33 cycles after accept.
//    HI=0xFFFFFFFE, LO=0x00000001; MFHI then MFLO return them; in_ready=0 throughout MUL.
//  3 MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//    MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  4 out_ready=0 for 5 cycles after SLT(-1,1) -> result=1 held stable, in_ready=0.
//    Release with in_valid SRL(A=4,B=0xF0) -> next result 0x0F with no bubble.
//  5 op=6'd63 -> result=0, out_err=1; a following MFLO shows LO unchanged.
//  6 Assert reset at MUL cycle 10 -> all outputs 0 asynchronously.
//    After release, MFHI=0 and in_ready=1; no stray out_valid.
//  Also rerun 1-3 with WIDTH=16 and WIDTH=64 (multiply latency = WIDTH+1).

Source files
------------

// File: rtl/seq_alu_core.sv
// EX-stage ALU with shift-add multiplier and HI/LO registers; one registered result per accepted op.
// Single-cycle ops take 1 cycle and multiplies take WIDTH+1; result is held while out_ready is low, and no new op is accepted meanwhile.
module seq_alu_core #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_err,
  output logic             busy
);

  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MULT  = 6'd24;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_SLT   = 6'd42;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state, state_nxt;
  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   hi, lo, mag_a, mag_b, ma, mb, alu_res;
  logic               neg, alu_err, accept, is_mul, is_signed, last;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;

  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_signed = (op == OP_MULT);
  assign busy      = (state == S_MUL);
  assign last      = (state == S_MUL) && (cnt == SHW'(WIDTH - 1));

  // Signed multiply runs on magnitudes; the most-negative value is exact as an unsigned magnitude.
  assign mag_a   = (is_signed && data_a[WIDTH-1]) ? -data_a : data_a;
  assign mag_b   = (is_signed && data_b[WIDTH-1]) ? -data_b : data_b;
  assign acc_nxt = acc + (mb[cnt] ? ({{WIDTH{1'b0}}, ma} << cnt) : '0);
  assign prod    = neg ? -acc_nxt : acc_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:   if (last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op)
      OP_ADD:            alu_res = data_a + data_b;
      OP_SUB:            alu_res = data_a - data_b;
      OP_AND:            alu_res = data_a & data_b;
      OP_OR:             alu_res = data_a | data_b;
      OP_SLT:            alu_res = {{(WIDTH-1){1'b0}}, $signed(data_a) < $signed(data_b)};
      OP_SRL:            alu_res = data_b >> data_a[SHW-1:0];
      OP_MFHI:           alu_res = hi;
      OP_MFLO:           alu_res = lo;
      OP_MULT, OP_MULTU: alu_res = '0;
      default:           alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_err   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      ma        <= '0;
      mb        <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          ma  <= mag_a;
          mb  <= mag_b;
          neg <= is_signed && (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
          acc <= '0;
          cnt <= '0;
        end else begin
          result    <= alu_res;
          out_err   <= alu_err;
          out_valid <= 1'b1;
        end
      end
      if (state == S_MUL) begin
        acc <= acc_nxt;
        cnt <= cnt + SHW'(1);
        if (last) begin
          hi        <= prod[2*WIDTH-1:WIDTH];
          lo        <= prod[WIDTH-1:0];
          result    <= prod[WIDTH-1:0];
          out_err   <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
